membus_arbiter: RTL
===================

// Module: membus_arbiter
// PURPOSE
//  Shares one memory bus between instruction fetch (read-only) and the data memory unit (memops: inst_is_memop).
//  Single outstanding transaction; data side has priority, with a starvation limit that guarantees fetch progress.
//  Sits between core fetch/memunit and the memory/bus bridge.
// PARAMETERS
//  ADDR_WIDTH    64  address width (XLEN)
//  DATA_WIDTH    64  data width; wmask width = DATA_WIDTH/8
//  MAX_D_STREAK  4   max consecutive data grants while fetch waits (>=1)
// PORTS
//  clk       in   1           clock
//  rst       in   1           synchronous reset, active-high
//  i_valid   in   1           fetch request valid
//  i_ready   out  1           fetch request accepted this cycle
//  i_addr    in   ADDR_WIDTH  fetch address
//  i_rvalid  out  1           fetch response valid
//  i_rdata   out  DATA_WIDTH  fetch response data
//  d_valid   in   1           data request valid
//  d_ready   out  1           data request accepted this cycle
//  d_addr    in   ADDR_WIDTH  data address
//  d_wen     in   1           1 = store/AMO write, 0 = read
//  d_wdata   in   DATA_WIDTH  write data
//  d_wmask   in   DATA_WIDTH/8  byte write mask
//  d_rvalid  out  1           data response valid (also for writes)
//  d_rdata   out  DATA_WIDTH  data response data
//  m_valid   out  1           memory request valid
//  m_ready   in   1           memory accepts request
//  m_addr    out  ADDR_WIDTH  memory address
//  m_wen     out  1           memory write enable (0 for fetch)
//  m_wdata   out  DATA_WIDTH  memory write data (0 for fetch)
//  m_wmask   out  DATA_WIDTH/8  memory byte mask (0 for fetch)
//  m_rvalid  in   1           memory response valid
//  m_rdata   in   DATA_WIDTH  memory response data
//  busy      out  1           transaction outstanding (state != IDLE)
// BEHAVIOUR
//  - State machine: IDLE, WAIT_I, WAIT_D. Regs: state, lock, lock_owner, streak.
//  - Reset: state=IDLE, lock=0, streak=0; i_rvalid=d_rvalid=0, busy=0; m_valid follows inputs (comb.) from first cycle.
//  - IDLE select: if lock, owner=lock_owner; else if d_valid && !(i_valid && streak==MAX_D_STREAK) owner=D;
//    else if i_valid owner=I. m_valid = owner's valid; m_* muxed from owner, combinational (0-latency request path).
//  - IDLE ready: owner_ready = m_ready; non-owner ready = 0.
//  - m_valid && !m_ready -> lock=1, lock_owner=owner: m_* held stable; no switch even if other side rises.
//  - m_valid && m_ready -> accept: lock=0, state=WAIT_I/WAIT_D by owner.
//  - streak on accept: D with i_valid=1 -> streak+1 (saturates at MAX_D_STREAK); D with i_valid=0 or I -> streak=0.
//  - WAIT_x: m_valid=0, i_ready=d_ready=0. m_rvalid -> x_rvalid=1 and x_rdata=m_rdata same cycle (comb.);
//    other rvalid=0; next state IDLE. New request accepted no earlier than the cycle after the response
//    (max 1 transaction / 2 cycles).
//  - m_rvalid in IDLE is ignored (no rvalid to either side). m_rvalid and m_ready never overlap for one transaction.
//  - Requesters hold valid/payload stable until ready; arbiter does not register payloads.
//  - rst mid-transaction: back to IDLE, pending response dropped; memory side must be reset in the same cycle.
//  - Non-owner rdata ports output 0.
// TESTING
//  1 Fetch only: i_valid=1, i_addr=0x1000, m_ready=1 -> m_addr=0x1000, m_wen=0, i_ready=1; m_rvalid 2 cyc later, rdata=0xABCD -> i_rvalid=1, i_rdata=0xABCD.
//  2 Same-cycle i_valid,d_valid (d_addr=0x2000) -> d wins, m_addr=0x2000, d_ready=1, i_ready=0; after response, fetch granted next IDLE.
//  3 d_valid,i_valid held high, MAX_D_STREAK=4 -> grants D,D,D,D,I,D,... (5th grant to fetch), streak back to 0.
//  4 Lock: i_valid=1, m_ready=0 for 3 cyc, d_valid rises cyc 1 -> m_addr stays i_addr; on m_ready=1 fetch accepted, then D.
//  5 Store: d_wen=1, d_wdata=0x11223344, d_wmask=0x0F -> m_* match; m_rvalid -> d_rvalid=1, i_rvalid=0; stray m_rvalid in IDLE -> no rvalid.
//  6 rst asserted in WAIT_D -> next cycle busy=0, state IDLE, streak=0; subsequent m_rvalid ignored.

Source files
------------

// File: rtl/membus_arbiter.sv
// -----------------------------------------------------------------------------
// membus_arbiter
//   Shares a single memory bus between instruction fetch (read-only) and the
//   data memory unit. Only one transaction is in flight at a time. The data
//   side normally wins, but after MAX_D_STREAK back-to-back data grants with
//   fetch waiting, fetch is granted so it always makes progress.
//
//   The request path is combinational: the selected requester's payload is
//   muxed straight onto m_*. Once a request is offered and stalled by
//   m_ready=0, the choice is locked until it is accepted, so m_* stay stable.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   i_valid/i_ready/i_addr        fetch request handshake and address
//   i_rvalid/i_rdata              fetch response
//   d_valid/d_ready/d_addr        data request handshake and address
//   d_wen/d_wdata/d_wmask         data write enable, data and byte mask
//   d_rvalid/d_rdata              data response (also signalled for writes)
//   m_valid/m_ready/m_addr        memory request handshake and address
//   m_wen/m_wdata/m_wmask         memory write controls (all 0 for fetch)
//   m_rvalid/m_rdata              memory response
//   busy                          a transaction is outstanding
// -----------------------------------------------------------------------------
module membus_arbiter #(
  parameter int ADDR_WIDTH   = 64,
  parameter int DATA_WIDTH   = 64,
  parameter int MAX_D_STREAK = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_valid,
  output logic                    i_ready,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  output logic                    i_rvalid,
  output logic [DATA_WIDTH-1:0]   i_rdata,
  input  logic                    d_valid,
  output logic                    d_ready,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic                    d_wen,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  input  logic [DATA_WIDTH/8-1:0] d_wmask,
  output logic                    d_rvalid,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [ADDR_WIDTH-1:0]   m_addr,
  output logic                    m_wen,
  output logic [DATA_WIDTH-1:0]   m_wdata,
  output logic [DATA_WIDTH/8-1:0] m_wmask,
  input  logic                    m_rvalid,
  input  logic [DATA_WIDTH-1:0]   m_rdata,
  output logic                    busy
);

  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

  typedef enum logic [1:0] {IDLE, WAIT_I, WAIT_D} state_e;
  typedef enum logic {OWN_I, OWN_D} owner_e;

  state_e        state_q, state_d;
  logic          lock_q, lock_d;
  owner_e        lock_owner_q, lock_owner_d;
  logic [SW-1:0] streak_q, streak_d;

  owner_e owner;
  logic   owner_vld;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      lock_q       <= 1'b0;
      lock_owner_q <= OWN_I;
      streak_q     <= '0;
    end else begin
      state_q      <= state_d;
      lock_q       <= lock_d;
      lock_owner_q <= lock_owner_d;
      streak_q     <= streak_d;
    end
  end

  // NOTE: every output and next-state value gets a default first, so no path
  // through the case leaves a signal unassigned (no latches).
  always_comb begin
    state_d      = state_q;
    lock_d       = lock_q;
    lock_owner_d = lock_owner_q;
    streak_d     = streak_q;
    owner        = OWN_I;
    owner_vld    = 1'b0;
    m_valid      = 1'b0;
    m_addr       = '0;
    m_wen        = 1'b0;
    m_wdata      = '0;
    m_wmask      = '0;
    i_ready      = 1'b0;
    d_ready      = 1'b0;
    i_rvalid     = 1'b0;
    i_rdata      = '0;
    d_rvalid     = 1'b0;
    d_rdata      = '0;

    case (state_q)
      IDLE: begin
        // A stalled offer keeps its owner; otherwise data wins unless fetch
        // has already waited through a full streak of data grants.
        if (lock_q) begin
          owner     = lock_owner_q;
          owner_vld = (lock_owner_q == OWN_D) ? d_valid : i_valid;
        end else if (d_valid && !(i_valid && streak_q == STREAK_MAX)) begin
          owner     = OWN_D;
          owner_vld = 1'b1;
        end else if (i_valid) begin
          owner     = OWN_I;
          owner_vld = 1'b1;
        end

        if (owner_vld) begin
          m_valid = 1'b1;
          if (owner == OWN_D) begin
            m_addr  = d_addr;
            m_wen   = d_wen;
            m_wdata = d_wdata;
            m_wmask = d_wmask;
            d_ready = m_ready;
          end else begin
            m_addr  = i_addr;
            i_ready = m_ready;
          end

          if (m_ready) begin
            lock_d  = 1'b0;
            state_d = (owner == OWN_D) ? WAIT_D : WAIT_I;
            if (owner == OWN_D && i_valid) begin
              if (streak_q != STREAK_MAX) streak_d = streak_q + 1'b1;
            end else begin
              streak_d = '0;
            end
          end else begin
            lock_d       = 1'b1;
            lock_owner_d = owner;
          end
        end
      end

      WAIT_I: begin
        if (m_rvalid) begin
          i_rvalid = 1'b1;
          i_rdata  = m_rdata;
          state_d  = IDLE;
        end
      end

      WAIT_D: begin
        if (m_rvalid) begin
          d_rvalid = 1'b1;
          d_rdata  = m_rdata;
          state_d  = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

endmodule
